// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the decode-stage interlock: register indexing,
// controller state encoding and the bubble instruction used downstream.
package pipe_pkg;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    // addi x0, x0, 0: what ID/EX loads when ex_bubble is asserted
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic int pend_width(input int inflight);
        return $clog2(inflight + 1);
    endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register count of writes issued from ID that have not yet retired at WB,
// with two ready lookups for the ID source operands and a sticky error flag.
module reg_scoreboard
    import pipe_pkg::*;
#(
    parameter int INFLIGHT  = 3,
    parameter int RF_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic [REG_W-1:0] inc_reg,
    input  logic             dec_en,
    input  logic [REG_W-1:0] dec_reg,
    input  logic [REG_W-1:0] rd_reg_a,
    input  logic [REG_W-1:0] rd_reg_b,
    output logic             ready_a,
    output logic             ready_b,
    output logic             err
);
    localparam int CW = pend_width(INFLIGHT);

    logic [CW-1:0]       pend_arr [NUM_REGS];
    logic [NUM_REGS-1:0] err_set;
    logic                err_q;
    logic [CW-1:0]       p_a;
    logic [CW-1:0]       p_b;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // x0 is hardwired; it never has a pending write
                assign pend_arr[gi] = '0;
                assign err_set[gi]  = 1'b0;
            end else begin : g_track
                logic [CW-1:0] pend_q;
                logic [CW-1:0] pend_d;
                logic          inc_hit;
                logic          dec_hit;
                logic          err_hit;

                assign inc_hit = inc_en && (inc_reg == REG_W'(gi));
                assign dec_hit = dec_en && (dec_reg == REG_W'(gi));

                always_comb begin
                    pend_d  = pend_q;
                    err_hit = 1'b0;
                    if (inc_hit && !dec_hit) begin
                        if (pend_q == CW'(INFLIGHT)) begin
                            err_hit = 1'b1;
                        end else begin
                            pend_d = pend_q + CW'(1);
                        end
                    end else if (dec_hit && !inc_hit) begin
                        if (pend_q == '0) begin
                            err_hit = 1'b1;
                        end else begin
                            pend_d = pend_q - CW'(1);
                        end
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        pend_q <= '0;
                    end else begin
                        pend_q <= pend_d;
                    end
                end

                assign pend_arr[gi] = pend_q;
                assign err_set[gi]  = err_hit;
            end
        end
    endgenerate

    assign p_a = pend_arr[rd_reg_a];
    assign p_b = pend_arr[rd_reg_b];

    // With write-through, the last outstanding write retiring this cycle satisfies the read
    assign ready_a = (rd_reg_a == '0) || (p_a == '0) ||
                     ((RF_BYPASS != 0) && dec_en && (dec_reg == rd_reg_a) && (p_a == CW'(1)));
    assign ready_b = (rd_reg_b == '0) || (p_b == '0) ||
                     ((RF_BYPASS != 0) && dec_en && (dec_reg == rd_reg_b) && (p_b == CW'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (|err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock and flush sequencer: stalls on pending source registers,
// squashes IF/ID after an EX redirect, and counts stall cycles.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int INFLIGHT     = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int RF_BYPASS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        ex_redirect,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_wregnum,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_id,
    output logic        ex_bubble,
    output logic        issue,
    output logic        busy_err,
    output logic [31:0] stall_cnt
);
    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  fcnt_q;
    logic [2:0]  fcnt_d;
    logic [31:0] stall_cnt_q;
    logic        rdy1;
    logic        rdy2;
    logic        hazard;
    logic        inc_en;
    logic        dec_en;

    assign inc_en = issue && id_regwrite && (id_rd != 5'd0);
    assign dec_en = wb_regwrite && (wb_wregnum != 5'd0);

    reg_scoreboard #(
        .INFLIGHT  (INFLIGHT),
        .RF_BYPASS (RF_BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (inc_en),
        .inc_reg  (id_rd),
        .dec_en   (dec_en),
        .dec_reg  (wb_wregnum),
        .rd_reg_a (id_rs1),
        .rd_reg_b (id_rs2),
        .ready_a  (rdy1),
        .ready_b  (rdy2),
        .err      (busy_err)
    );

    assign hazard = id_valid && ((id_use_rs1 && !rdy1) || (id_use_rs2 && !rdy2));

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        ex_bubble = 1'b0;
        issue     = 1'b0;
        case (state_q)
            RUN: begin
                // a redirect outranks a hazard: the stalled instruction is on the wrong path
                if (ex_redirect) begin
                    flush_id  = 1'b1;
                    ex_bubble = 1'b1;
                    if (FLUSH_CYCLES == 1) begin
                        state_d = RUN;
                        fcnt_d  = 3'd0;
                    end else begin
                        state_d = FLUSH;
                        fcnt_d  = FCNT_INIT;
                    end
                end else if (hazard) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    ex_bubble = 1'b1;
                end else begin
                    issue     = id_valid;
                    ex_bubble = !id_valid;
                end
            end
            FLUSH: begin
                flush_id  = 1'b1;
                ex_bubble = 1'b1;
                if (ex_redirect) begin
                    fcnt_d = FCNT_INIT;
                end else if (fcnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (stall_id) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Two controllers (bypass/2-cycle flush and no-bypass/3-cycle flush) driven by the
// same stimulus; expectations come from a behavioural model and are checked by a monitor.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_wregnum = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regwrite = 1'b0;
    logic       ex_redirect = 1'b0, wb_regwrite = 1'b0;

    logic [1:0]  o_sif, o_sid, o_fid, o_bub, o_iss, o_err;
    logic [31:0] o_cnt [2];

    hazard_ctrl #(.INFLIGHT(3), .FLUSH_CYCLES(2), .RF_BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .ex_redirect(ex_redirect), .wb_regwrite(wb_regwrite),
        .wb_wregnum(wb_wregnum), .stall_if(o_sif[0]), .stall_id(o_sid[0]),
        .flush_id(o_fid[0]), .ex_bubble(o_bub[0]), .issue(o_iss[0]),
        .busy_err(o_err[0]), .stall_cnt(o_cnt[0]));

    hazard_ctrl #(.INFLIGHT(3), .FLUSH_CYCLES(3), .RF_BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .ex_redirect(ex_redirect), .wb_regwrite(wb_regwrite),
        .wb_wregnum(wb_wregnum), .stall_if(o_sif[1]), .stall_id(o_sid[1]),
        .flush_id(o_fid[1]), .ex_bubble(o_bub[1]), .issue(o_iss[1]),
        .busy_err(o_err[1]), .stall_cnt(o_cnt[1]));

    typedef struct {
        bit          sif, sid, fid, bub, iss, berr;
        logic [31:0] cnt;
        int          txn;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Model state: outstanding write count per register, flush cycles still to come
    int          m_pend  [2][32];
    int          m_flush [2];
    logic [31:0] m_cnt   [2];
    bit          m_err   [2];
    int          fc_of   [2] = '{2, 3};
    int          byp_of  [2] = '{1, 0};

    task automatic chk(input string nm, input int k, input int t,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst %0d txn %0d: got %0h want %0h", nm, k, t, act, exp);
        end
    endtask

    function automatic bit m_ready(input int k, input int r);
        if (r == 0 || m_pend[k][r] == 0) return 1'b1;
        return (byp_of[k] != 0) && wb_regwrite && (int'(wb_wregnum) == r) && (m_pend[k][r] == 1);
    endfunction

    task automatic model_step(input int k, output exp_t e);
        bit hz;
        int nf;
        e = '{default: 0};
        e.txn = txn;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_pend[k][r] = 0;
            m_flush[k] = 0;
            m_cnt[k]   = 0;
            m_err[k]   = 0;
        end
        e.cnt  = m_cnt[k];
        e.berr = m_err[k];
        hz = id_valid && ((id_use_rs1 && !m_ready(k, int'(id_rs1))) ||
                          (id_use_rs2 && !m_ready(k, int'(id_rs2))));
        nf = 0;
        if (m_flush[k] > 0) begin
            e.fid = 1; e.bub = 1;
            nf = ex_redirect ? fc_of[k] : m_flush[k] - 1;
        end else if (ex_redirect) begin
            e.fid = 1; e.bub = 1;
            nf = (fc_of[k] == 1) ? 0 : fc_of[k];
        end else if (hz) begin
            e.sif = 1; e.sid = 1; e.bub = 1;
        end else begin
            e.iss = id_valid; e.bub = !id_valid;
        end
        if (!rst) begin
            int  ir, dr;
            bit  inc, dec;
            ir  = int'(id_rd);
            dr  = int'(wb_wregnum);
            inc = e.iss && id_regwrite && ir != 0;
            dec = wb_regwrite && dr != 0;
            if (!(inc && dec && ir == dr)) begin
                if (inc) begin
                    if (m_pend[k][ir] == 3) m_err[k] = 1; else m_pend[k][ir]++;
                end
                if (dec) begin
                    if (m_pend[k][dr] == 0) m_err[k] = 1; else m_pend[k][dr]--;
                end
            end
            m_flush[k] = nf;
            if (e.sid) m_cnt[k] = m_cnt[k] + 32'd1;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [4:0] s1, input logic [4:0] s2,
                        input bit u1, input bit u2, input logic [4:0] rd, input bit rw,
                        input bit redir, input bit wbw, input logic [4:0] wbn);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs1 = s1; id_rs2 = s2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw; ex_redirect = redir; wb_regwrite = wbw; wb_wregnum = wbn;
        txn++;
        model_step(0, e); q0.push_back(e);
        model_step(1, e); q1.push_back(e);
    endtask

    task automatic compare(input int k, input exp_t e);
        $display("txn %0d inst %0d rst=%b iss=%b sid=%b fid=%b bub=%b err=%b cnt=%0d",
                 e.txn, k, rst, o_iss[k], o_sid[k], o_fid[k], o_bub[k], o_err[k], o_cnt[k]);
        chk("stall_if",  k, e.txn, 32'(o_sif[k]), 32'(e.sif));
        chk("stall_id",  k, e.txn, 32'(o_sid[k]), 32'(e.sid));
        chk("flush_id",  k, e.txn, 32'(o_fid[k]), 32'(e.fid));
        chk("ex_bubble", k, e.txn, 32'(o_bub[k]), 32'(e.bub));
        chk("issue",     k, e.txn, 32'(o_iss[k]), 32'(e.iss));
        chk("busy_err",  k, e.txn, 32'(o_err[k]), 32'(e.berr));
        chk("stall_cnt", k, e.txn, o_cnt[k], e.cnt);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            compare(0, e);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            compare(1, e);
        end
    end

    task automatic dchk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        chk(nm, k, txn, act, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog inst 0 txn %0d: got timeout want finish", txn);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with a reader of x5 in ID: no stall from reset itself
        step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_reset_issue", 0, 32'(o_iss[0]), 32'd1);
        dchk("tp_reset_cnt", 0, o_cnt[0], 32'd0);
        // addi x5, then a reader of x5 until WB retires it
        step(0, 1, 0, 0, 1, 0, 5, 1, 0, 0, 0);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_stall_id", 0, 32'(o_sid[0]), 32'd1);
        dchk("tp_stall_if", 0, 32'(o_sif[0]), 32'd1);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0, 1, 5);
        @(negedge clk); #1;
        dchk("tp_bypass_issue", 0, 32'(o_iss[0]), 32'd1);
        dchk("tp_nobypass_stall", 1, 32'(o_sid[1]), 32'd1);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_cnt_bypass", 0, o_cnt[0], 32'd2);
        dchk("tp_cnt_nobypass", 1, o_cnt[1], 32'd3);
        // redirect while a hazard on x6 is present
        step(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        step(0, 1, 0, 6, 0, 1, 0, 0, 1, 0, 0);
        @(negedge clk); #1;
        dchk("tp_redir_flush", 0, 32'(o_fid[0]), 32'd1);
        dchk("tp_redir_nostall", 0, 32'(o_sid[0]), 32'd0);
        step(0, 1, 0, 6, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 6, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_flush_last", 0, 32'(o_fid[0]), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        @(negedge clk); #1;
        dchk("tp_flush_done", 0, 32'(o_fid[0]), 32'd0);
        dchk("tp_flush3", 1, 32'(o_fid[1]), 32'd1);
        // x7: simultaneous inc/dec, then saturation
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 7);
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_err_before", 0, 32'(o_err[0]), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_err_sat", 0, 32'(o_err[0]), 32'd1);
        // x0 is never tracked
        step(0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_x0_nostall", 0, 32'(o_sid[0]), 32'd0);
        dchk("tp_x0_issue", 0, 32'(o_iss[0]), 32'd1);
        // reset in the middle of a flush
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_in_flush", 0, 32'(o_fid[0]), 32'd1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        dchk("tp_rst_flush", 0, 32'(o_fid[0]), 32'd0);
        dchk("tp_rst_err", 0, 32'(o_err[0]), 32'd0);

        // randomized traffic over a small register window to force collisions
        for (int blk = 0; blk < 6; blk++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 59; c++) begin
                step(0, ($urandom % 4) != 0, 5'($urandom % 8), 5'($urandom % 8),
                     1'($urandom % 2), 1'($urandom % 2), 5'($urandom % 8), 1'($urandom % 2),
                     ($urandom % 12) == 0, ($urandom % 3) == 0, 5'($urandom % 8));
            end
        end

        @(negedge clk); #2;
        chk("queue_drain", 0, txn, 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
